sensor_frame_packer: RTL and testbench

//  Downstream consumer of the per-sensor 16->8 cache FIFOs. Round-robin scans SENSOR_NUM channels.

---
 rtl/sensor_frame_packer.sv | 196 +++++++++++++++++++
 tb/tb_sensor_frame_packer.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sensor_frame_packer.sv
// Round-robin packer: drains PKT_LEN bytes from one eligible sensor FIFO into a
// framed byte stream (sync word, header, payload, checksum) with valid/ready/last.

module sfp_lane #(
  parameter int PKT_LEN = 256
) (
  input  logic [15:0] i_count,
  input  logic        i_empty,
  input  logic        i_sel,
  input  logic        i_rd_req,
  output logic        o_eligible,
  output logic        o_rd_en
);
  localparam logic [15:0] LEN16 = 16'(PKT_LEN);

  assign o_eligible = (i_count >= LEN16) && !i_empty;
  assign o_rd_en    = i_sel && i_rd_req && !i_empty;
endmodule

module sensor_frame_packer #(
  parameter int          SENSOR_NUM = 20,
  parameter int          PKT_LEN    = 256,
  parameter logic [15:0] HEAD       = 16'hEB90
) (
  input  logic                     sys_clk_i,
  input  logic                     rst_i,
  input  logic                     enable_i,
  output logic [SENSOR_NUM-1:0]    rd_en_o,
  input  logic [SENSOR_NUM*8-1:0]  rd_dout_i,
  input  logic [SENSOR_NUM-1:0]    empty_i,
  input  logic [SENSOR_NUM*16-1:0] rd_data_count_i,
  output logic [7:0]               m_tdata_o,
  output logic                     m_tvalid_o,
  input  logic                     m_tready_i,
  output logic                     m_tlast_o,
  output logic [31:0]              frame_cnt_o,
  output logic                     busy_o
);
  localparam int              PW      = (SENSOR_NUM > 1) ? $clog2(SENSOR_NUM) : 1;
  localparam logic [15:0]     LEN16   = 16'(PKT_LEN);
  localparam logic [PW-1:0]   LAST_CH = PW'(SENSOR_NUM - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SCAN, S_HDR, S_RD_REQ, S_RD_WAIT, S_PAY, S_CKS
  } state_t;

  state_t          r_state, w_next;
  logic [PW-1:0]   r_ptr, r_ch;
  logic [2:0]      r_hidx;
  logic [15:0]     r_bcnt;
  logic [7:0]      r_seq, r_cks, r_tdata;
  logic            r_tvalid, r_tlast;
  logic [31:0]     r_frame_cnt;

  logic [SENSOR_NUM-1:0][7:0]  w_dout;
  logic [SENSOR_NUM-1:0][15:0] w_count;
  logic [SENSOR_NUM-1:0]       w_elig, w_sel;
  logic                        w_hs, w_hit, w_rd_go, w_rd_req;
  logic [PW-1:0]               w_ptr_inc, w_ch_inc;
  logic [7:0]                  w_ch8, w_hdr_byte, w_rd_byte;

  assign w_dout  = rd_dout_i;
  assign w_count = rd_data_count_i;

  genvar g;
  generate
    for (g = 0; g < SENSOR_NUM; g++) begin : g_lane
      assign w_sel[g] = (r_ch == PW'(g));
      sfp_lane #(.PKT_LEN(PKT_LEN)) u_lane (
        .i_count    (w_count[g]),
        .i_empty    (empty_i[g]),
        .i_sel      (w_sel[g]),
        .i_rd_req   (w_rd_req),
        .o_eligible (w_elig[g]),
        .o_rd_en    (rd_en_o[g])
      );
    end
  endgenerate

  assign w_rd_req  = (r_state == S_RD_REQ);
  assign w_rd_go   = |rd_en_o;
  assign w_hs      = r_tvalid && m_tready_i;
  assign w_hit     = (r_state == S_SCAN) && enable_i && w_elig[r_ptr];
  assign w_ptr_inc = (r_ptr == LAST_CH) ? '0 : r_ptr + PW'(1);
  assign w_ch_inc  = (r_ch == LAST_CH) ? '0 : r_ch + PW'(1);
  assign w_ch8     = 8'(r_ch);
  assign w_rd_byte = w_dout[r_ch];

  // Header byte that follows the one currently presented (index r_hidx).
  always_comb begin
    w_hdr_byte = HEAD[15:8];
    case (r_hidx)
      3'd0:    w_hdr_byte = HEAD[7:0];
      3'd1:    w_hdr_byte = w_ch8;
      3'd2:    w_hdr_byte = r_seq;
      3'd3:    w_hdr_byte = LEN16[15:8];
      3'd4:    w_hdr_byte = LEN16[7:0];
      default: w_hdr_byte = HEAD[15:8];
    endcase
  end

  always_ff @(posedge sys_clk_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (enable_i) w_next = S_SCAN;
      S_SCAN: begin
        if (!enable_i)  w_next = S_IDLE;
        else if (w_hit) w_next = S_HDR;
      end
      S_HDR:     if (w_hs && r_hidx == 3'd5) w_next = S_RD_REQ;
      S_RD_REQ:  if (w_rd_go) w_next = S_RD_WAIT;
      S_RD_WAIT: w_next = S_PAY;
      S_PAY:     if (w_hs) w_next = (r_bcnt == LEN16) ? S_CKS : S_RD_REQ;
      S_CKS:     if (w_hs) w_next = enable_i ? S_SCAN : S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk_i) begin
    if (rst_i) begin
      r_ptr       <= '0;
      r_ch        <= '0;
      r_hidx      <= '0;
      r_bcnt      <= '0;
      r_seq       <= '0;
      r_cks       <= '0;
      r_tdata     <= '0;
      r_tvalid    <= 1'b0;
      r_tlast     <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      case (r_state)
        S_SCAN: begin
          if (w_hit) begin
            // Checksum seeds with the header fields it covers; sync word excluded.
            r_ch     <= r_ptr;
            r_hidx   <= '0;
            r_bcnt   <= '0;
            r_cks    <= 8'(r_ptr) + r_seq + LEN16[15:8] + LEN16[7:0];
            r_tdata  <= HEAD[15:8];
            r_tvalid <= 1'b1;
          end else if (enable_i) begin
            r_ptr <= w_ptr_inc;
          end
        end
        S_HDR: begin
          if (w_hs) begin
            if (r_hidx == 3'd5) begin
              r_tvalid <= 1'b0;
            end else begin
              r_hidx  <= r_hidx + 3'd1;
              r_tdata <= w_hdr_byte;
            end
          end
        end
        S_RD_WAIT: begin
          r_tdata  <= w_rd_byte;
          r_tvalid <= 1'b1;
          r_cks    <= r_cks + w_rd_byte;
          r_bcnt   <= r_bcnt + 16'd1;
        end
        S_PAY: begin
          if (w_hs) begin
            if (r_bcnt == LEN16) begin
              r_tdata <= r_cks;
              r_tlast <= 1'b1;
            end else begin
              r_tvalid <= 1'b0;
            end
          end
        end
        S_CKS: begin
          if (w_hs) begin
            r_tvalid    <= 1'b0;
            r_tlast     <= 1'b0;
            r_seq       <= r_seq + 8'd1;
            r_frame_cnt <= r_frame_cnt + 32'd1;
            r_ptr       <= w_ch_inc;
          end
        end
        default: ;
      endcase
    end
  end

  assign m_tdata_o   = r_tdata;
  assign m_tvalid_o  = r_tvalid;
  assign m_tlast_o   = r_tlast;
  assign frame_cnt_o = r_frame_cnt;
  assign busy_o      = !(r_state == S_IDLE || r_state == S_SCAN);
endmodule

// File: tb/tb_sensor_frame_packer.sv
// Directed bench for sensor_frame_packer: behavioural FIFOs feed the DUT, a
// monitor collects accepted bytes and protocol violations, tasks compare frames.

module tb_sensor_frame_packer;
  localparam int SN = 4;
  localparam int PL = 8;
  localparam int FL = PL + 7;

  logic clk = 1'b0, rst = 1'b1, en = 1'b0, tready = 1'b0;
  logic [SN-1:0]    rd_en, empty_bus;
  logic [SN*8-1:0]  dout_bus;
  logic [SN*16-1:0] cnt_bus;
  logic [7:0]       tdata;
  logic             tvalid, tlast, busy;
  logic [31:0]      fcnt;
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  sensor_frame_packer #(.SENSOR_NUM(SN), .PKT_LEN(PL), .HEAD(16'hEB90)) dut (
    .sys_clk_i(clk), .rst_i(rst), .enable_i(en),
    .rd_en_o(rd_en), .rd_dout_i(dout_bus), .empty_i(empty_bus),
    .rd_data_count_i(cnt_bus),
    .m_tdata_o(tdata), .m_tvalid_o(tvalid), .m_tready_i(tready),
    .m_tlast_o(tlast), .frame_cnt_o(fcnt), .busy_o(busy)
  );

  // Standard-mode FIFO models: data appears one clock after the read strobe.
  logic [7:0] mem [SN][4096];
  int         wp [SN] = '{default: 0};
  int         rp [SN] = '{default: 0};
  logic [7:0] dq [SN] = '{default: 8'h00};

  always @(posedge clk)
    for (int i = 0; i < SN; i++)
      if (rd_en[i]) begin
        dq[i] <= mem[i][rp[i] % 4096];
        rp[i] <= rp[i] + 1;
      end

  for (genvar g = 0; g < SN; g++) begin : g_fifo
    assign dout_bus[g*8 +: 8]   = dq[g];
    assign cnt_bus[g*16 +: 16]  = 16'(wp[g] - rp[g]);
    assign empty_bus[g]         = (wp[g] == rp[g]);
  end

  // Monitor, sampling on the falling edge.
  logic [8:0] got [$];
  int         nframes = 0, viol = 0;
  int         rdcnt [SN] = '{default: 0};
  logic       prev_stall = 1'b0, prev_last = 1'b0;
  logic [7:0] prev_data = 8'h00;

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && (!tvalid || tdata !== prev_data || tlast !== prev_last)) viol++;
      if ($countones(rd_en) > 1) viol++;
      if (tvalid && rd_en != '0) viol++;
      for (int i = 0; i < SN; i++) if (rd_en[i]) rdcnt[i]++;
      if (tvalid && tready) begin
        got.push_back({tlast, tdata});
        if (tlast) nframes++;
      end
      prev_stall = tvalid && !tready;
      prev_data  = tdata;
      prev_last  = tlast;
    end
  end

  logic [8:0] exp_q [$];

  // Checksum covers CH through the last payload byte.
  function automatic void add_frame(int ch, int seq, int start);
    logic [7:0] c, b;
    c = 8'(ch + seq + (PL >> 8) + (PL & 255));
    exp_q.push_back({1'b0, 8'hEB});
    exp_q.push_back({1'b0, 8'h90});
    exp_q.push_back({1'b0, 8'(ch)});
    exp_q.push_back({1'b0, 8'(seq)});
    exp_q.push_back({1'b0, 8'(PL >> 8)});
    exp_q.push_back({1'b0, 8'(PL)});
    for (int k = 0; k < PL; k++) begin
      b = 8'(start + k);
      exp_q.push_back({1'b0, b});
      c = c + b;
    end
    exp_q.push_back({1'b1, c});
  endfunction

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic fill(int ch, int start, int n);
    for (int k = 0; k < n; k++) begin
      mem[ch][wp[ch] % 4096] = 8'(start + k);
      wp[ch] = wp[ch] + 1;
    end
  endtask

  task automatic do_reset();
    en = 1'b0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    for (int i = 0; i < SN; i++) wp[i] = rp[i];
    step();
  endtask

  task automatic wait_frames(int target, int budget);
    for (int c = 0; c < budget && nframes < target; c++) step();
  endtask

  task automatic test_reset();
    tready = 1'b1;
    rst = 1'b1;
    step(); step(); step();
    checks++; if (tvalid !== 1'b0) begin failures++; $display("FAIL reset_tvalid got=%b exp=0", tvalid); end
    checks++; if (tlast !== 1'b0) begin failures++; $display("FAIL reset_tlast got=%b exp=0", tlast); end
    checks++; if (tdata !== 8'h00) begin failures++; $display("FAIL reset_tdata got=%h exp=00", tdata); end
    checks++; if (rd_en !== '0) begin failures++; $display("FAIL reset_rd_en got=%b exp=0", rd_en); end
    checks++; if (fcnt !== 32'd0) begin failures++; $display("FAIL reset_frame_cnt got=%0d exp=0", fcnt); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_single_frame();
    int nb, gb, rb, gi;
    do_reset();
    nb = nframes; gb = got.size(); rb = rdcnt[2];
    exp_q.delete();
    add_frame(2, 0, 1);
    fill(2, 1, 8);
    en = 1'b1;
    wait_frames(nb + 1, 300);
    checks++; if (nframes - nb !== 1) begin failures++; $display("FAIL single_frames got=%0d exp=1", nframes - nb); end
    for (int i = 0; i < FL; i++) begin
      gi = gb + i;
      checks++;
      if (gi >= got.size()) begin
        failures++; $display("FAIL single_byte%0d got=missing exp=%h", i, exp_q[i]);
      end else if (got[gi] !== exp_q[i]) begin
        failures++; $display("FAIL single_byte%0d got=%h exp=%h", i, got[gi], exp_q[i]);
      end
    end
    checks++; if (rdcnt[2] - rb !== 8) begin failures++; $display("FAIL single_rd_pulses got=%0d exp=8", rdcnt[2] - rb); end
    checks++; if (fcnt !== 32'd1) begin failures++; $display("FAIL single_frame_cnt got=%0d exp=1", fcnt); end
    step(); step();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_busy_after got=%b exp=0", busy); end
  endtask

  task automatic test_two_channels();
    int nb, gb, bad, gi;
    do_reset();
    nb = nframes; gb = got.size();
    exp_q.delete();
    add_frame(0, 0, 8'h10);
    add_frame(3, 1, 8'hA0);
    fill(0, 8'h10, 8);
    fill(3, 8'hA0, 8);
    en = 1'b1;
    wait_frames(nb + 2, 400);
    checks++; if (nframes - nb !== 2) begin failures++; $display("FAIL two_ch_frames got=%0d exp=2", nframes - nb); end
    for (int f = 0; f < 2; f++) begin
      bad = -1;
      for (int i = 0; i < FL; i++) begin
        gi = gb + f*FL + i;
        if (bad < 0 && (gi >= got.size() || got[gi] !== exp_q[f*FL + i])) bad = i;
      end
      checks++;
      if (bad >= 0) begin failures++; $display("FAIL two_ch_frame%0d first bad byte %0d exp=%h", f, bad, exp_q[f*FL + bad]); end
    end
    checks++; if (fcnt !== 32'd2) begin failures++; $display("FAIL two_ch_frame_cnt got=%0d exp=2", fcnt); end
  endtask

  task automatic test_backpressure();
    int nb, gb, rb, vb, bad, gi;
    do_reset();
    nb = nframes; gb = got.size(); rb = rdcnt[2]; vb = viol;
    exp_q.delete();
    add_frame(2, 0, 1);
    fill(2, 1, 8);
    en = 1'b1;
    for (int c = 0; c < 600 && nframes < nb + 1; c++) begin
      tready = ~tready;
      step();
    end
    tready = 1'b1;
    bad = -1;
    for (int i = 0; i < FL; i++) begin
      gi = gb + i;
      if (bad < 0 && (gi >= got.size() || got[gi] !== exp_q[i])) bad = i;
    end
    checks++; if (bad >= 0) begin failures++; $display("FAIL bp_frame first bad byte %0d exp=%h", bad, exp_q[bad]); end
    checks++; if (got.size() - gb !== FL) begin failures++; $display("FAIL bp_len got=%0d exp=%0d", got.size() - gb, FL); end
    checks++; if (viol - vb !== 0) begin failures++; $display("FAIL bp_protocol violations got=%0d exp=0", viol - vb); end
    checks++; if (rdcnt[2] - rb !== 8) begin failures++; $display("FAIL bp_rd_pulses got=%0d exp=8", rdcnt[2] - rb); end
  endtask

  task automatic test_seq_wrap();
    int nb, gb, bad, gi, badf;
    do_reset();
    nb = nframes; gb = got.size();
    exp_q.delete();
    for (int f = 0; f < 256; f++) add_frame(1, f, f * 8);
    fill(1, 0, 2048);
    en = 1'b1;
    wait_frames(nb + 256, 256 * 60);
    checks++; if (nframes - nb !== 256) begin failures++; $display("FAIL wrap_frames got=%0d exp=256", nframes - nb); end
    checks++; if (fcnt !== 32'd256) begin failures++; $display("FAIL wrap_frame_cnt got=%0d exp=256", fcnt); end
    badf = 0;
    for (int f = 0; f < 256; f++) begin
      bad = -1;
      for (int i = 0; i < FL; i++) begin
        gi = gb + f*FL + i;
        if (bad < 0 && (gi >= got.size() || got[gi] !== exp_q[f*FL + i])) bad = i;
      end
      if (bad >= 0) badf++;
    end
    checks++; if (badf !== 0) begin failures++; $display("FAIL wrap_frames_content bad frames got=%0d exp=0", badf); end
    gb = got.size(); nb = nframes;
    exp_q.delete();
    add_frame(1, 0, 8'h55);
    fill(1, 8'h55, 8);
    wait_frames(nb + 1, 300);
    checks++;
    if (gb + 3 >= got.size()) begin failures++; $display("FAIL wrap_seq00 got=missing exp=000"); end
    else if (got[gb + 3] !== 9'h000) begin failures++; $display("FAIL wrap_seq00 got=%h exp=000", got[gb + 3]); end
    bad = -1;
    for (int i = 0; i < FL; i++) begin
      gi = gb + i;
      if (bad < 0 && (gi >= got.size() || got[gi] !== exp_q[i])) bad = i;
    end
    checks++; if (bad >= 0) begin failures++; $display("FAIL wrap_frame257 first bad byte %0d exp=%h", bad, exp_q[bad]); end
    checks++; if (fcnt !== 32'd257) begin failures++; $display("FAIL wrap_frame_cnt257 got=%0d exp=257", fcnt); end
  endtask

  task automatic test_reset_mid_frame();
    int nb, gb, rb, bad, gi;
    do_reset();
    rb = rdcnt[1];
    fill(1, 8'h30, 8);
    en = 1'b1;
    for (int c = 0; c < 200 && (rdcnt[1] - rb) < 4; c++) step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (tvalid !== 1'b0) begin failures++; $display("FAIL rstmid_tvalid got=%b exp=0", tvalid); end
    checks++; if (tlast !== 1'b0) begin failures++; $display("FAIL rstmid_tlast got=%b exp=0", tlast); end
    checks++; if (tdata !== 8'h00) begin failures++; $display("FAIL rstmid_tdata got=%h exp=00", tdata); end
    checks++; if (rd_en !== '0) begin failures++; $display("FAIL rstmid_rd_en got=%b exp=0", rd_en); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
    checks++; if (fcnt !== 32'd0) begin failures++; $display("FAIL rstmid_frame_cnt got=%0d exp=0", fcnt); end
    wp[1] = rp[1];
    nb = nframes; gb = got.size();
    exp_q.delete();
    add_frame(1, 0, 8'h50);
    fill(1, 8'h50, 8);
    wait_frames(nb + 1, 300);
    bad = -1;
    for (int i = 0; i < FL; i++) begin
      gi = gb + i;
      if (bad < 0 && (gi >= got.size() || got[gi] !== exp_q[i])) bad = i;
    end
    checks++; if (bad >= 0) begin failures++; $display("FAIL rstmid_new_frame first bad byte %0d exp=%h", bad, exp_q[bad]); end
    checks++; if (fcnt !== 32'd1) begin failures++; $display("FAIL rstmid_frame_cnt_after got=%0d exp=1", fcnt); end
  endtask

  task automatic test_enable_drop();
    int nb, gb, bad, gi;
    do_reset();
    nb = nframes; gb = got.size();
    exp_q.delete();
    add_frame(0, 0, 8'h60);
    fill(0, 8'h60, 8);
    fill(2, 8'h70, 8);
    fill(3, 8'h80, 8);
    en = 1'b1;
    for (int c = 0; c < 50 && (got.size() - gb) < 2; c++) step();
    en = 1'b0;
    wait_frames(nb + 1, 300);
    for (int c = 0; c < 60; c++) step();
    checks++; if (nframes - nb !== 1) begin failures++; $display("FAIL endrop_frames got=%0d exp=1", nframes - nb); end
    checks++; if (got.size() - gb !== FL) begin failures++; $display("FAIL endrop_len got=%0d exp=%0d", got.size() - gb, FL); end
    bad = -1;
    for (int i = 0; i < FL; i++) begin
      gi = gb + i;
      if (bad < 0 && (gi >= got.size() || got[gi] !== exp_q[i])) bad = i;
    end
    checks++; if (bad >= 0) begin failures++; $display("FAIL endrop_frame first bad byte %0d exp=%h", bad, exp_q[bad]); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL endrop_busy got=%b exp=0", busy); end
    checks++; if (fcnt !== 32'd1) begin failures++; $display("FAIL endrop_frame_cnt got=%0d exp=1", fcnt); end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_two_channels();
    test_backpressure();
    test_seq_wrap();
    test_reset_mid_frame();
    test_enable_drop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
